// File: rtl/swipt_bridge_pwm.sv
// swipt_bridge_pwm: H-bridge gate-drive generator, shadowed config, per-leg dead time.
// Define SWIPT_DUTY_PERMILLE_EN to interpret cfg_on as per-mille of the half-period.
module swipt_bridge_pwm #(
   parameter int CNT_W    = 16,
   parameter int DEAD_W   = 4,
   parameter int DEAD_RST = 14
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              enable,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CNT_W-1:0]  cfg_period,
   input  logic [CNT_W-1:0]  cfg_on,
   input  logic [DEAD_W-1:0] cfg_dead,
   output logic              cfg_err,
   output logic              hs_l,
   output logic              hs_r,
   output logic              ls_l,
   output logic              ls_r,
   output logic              period_start,
   output logic              active
);
   typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
   state_t r_state, w_next;
   logic [CNT_W-1:0] r_cnt, r_sp, r_son, r_p, r_on, w_h, w_on_new, w_son_in;
   logic [DEAD_W-1:0] r_sd, r_d, r_tmr_l, r_tmr_r;
   logic r_pend, r_err, r_dem_l, r_dem_r, r_cur_l, r_cur_r;
   logic w_xfer, w_ok, w_wrap, w_copy, w_gap_l, w_gap_r;
`ifdef SWIPT_DUTY_PERMILLE_EN
   logic [2*CNT_W-1:0] w_prod;
   assign w_ok     = cfg_period >= CNT_W'(4);
   assign w_son_in = (cfg_on > CNT_W'(1000)) ? CNT_W'(1000) : cfg_on;
   // effective on-time is scaled by the new period's half when the copy happens
   assign w_prod   = {{CNT_W{1'b0}}, r_sp >> 1} * {{CNT_W{1'b0}}, r_son};
   assign w_on_new = CNT_W'(w_prod / (2*CNT_W)'(1000));
`else
   assign w_ok     = cfg_period >= CNT_W'(4) && cfg_on <= (cfg_period >> 1);
   assign w_son_in = cfg_on;
   assign w_on_new = r_son;
`endif
   assign w_h    = r_p >> 1;
   assign active = r_state != IDLE;
   assign w_wrap = active && r_cnt == r_p - 1'b1;
   assign w_xfer = cfg_valid && !r_pend;
   assign w_copy = r_pend && (!active || w_wrap);
   assign cfg_ready    = !r_pend;
   assign cfg_err      = r_err;
   assign period_start = active && r_cnt == '0;
   // the most recent demand change owns the dead window
   assign w_gap_l = (r_dem_l != r_cur_l) ? r_d != '0 : r_tmr_l != '0;
   assign w_gap_r = (r_dem_r != r_cur_r) ? r_d != '0 : r_tmr_r != '0;
   assign hs_l = active && !w_gap_l && r_dem_l;
   assign ls_l = !active || (!w_gap_l && !r_dem_l);
   assign hs_r = active && !w_gap_r && r_dem_r;
   assign ls_r = !active || (!w_gap_r && !r_dem_r);

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = (enable && r_p >= CNT_W'(4)) ? RUN : IDLE;
         RUN:     w_next = enable ? RUN : (w_wrap ? IDLE : STOP);
         default: w_next = enable ? RUN : (w_wrap ? IDLE : STOP);
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_sp    <= '0;
         r_son   <= '0;
         r_sd    <= DEAD_W'(DEAD_RST);
         r_p     <= '0;
         r_on    <= '0;
         r_d     <= DEAD_W'(DEAD_RST);
         r_pend  <= 1'b0;
         r_err   <= 1'b0;
         r_dem_l <= 1'b0;
         r_dem_r <= 1'b0;
         r_cur_l <= 1'b0;
         r_cur_r <= 1'b0;
         r_tmr_l <= '0;
         r_tmr_r <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= (!active || w_wrap) ? '0 : r_cnt + 1'b1;
         r_err   <= w_xfer && !w_ok;
         r_pend  <= (w_xfer && w_ok) ? 1'b1 : (w_copy ? 1'b0 : r_pend);
         if (w_xfer && w_ok) begin
            r_sp  <= cfg_period;
            r_son <= w_son_in;
            r_sd  <= cfg_dead;
         end
         if (w_copy) begin
            r_p  <= r_sp;
            r_on <= w_on_new;
            r_d  <= r_sd;
         end
         r_dem_l <= active && r_cnt < r_on;
         r_dem_r <= active && r_cnt >= w_h && (r_cnt - w_h) < r_on;
         if (!active) begin
            r_cur_l <= 1'b0;
            r_cur_r <= 1'b0;
            r_tmr_l <= '0;
            r_tmr_r <= '0;
         end else begin
            r_cur_l <= r_dem_l;
            r_cur_r <= r_dem_r;
            r_tmr_l <= (r_dem_l != r_cur_l) ? ((r_d == '0) ? '0 : r_d - 1'b1) :
                       ((r_tmr_l == '0) ? '0 : r_tmr_l - 1'b1);
            r_tmr_r <= (r_dem_r != r_cur_r) ? ((r_d == '0) ? '0 : r_d - 1'b1) :
                       ((r_tmr_r == '0) ? '0 : r_tmr_r - 1'b1);
         end
      end
   end
endmodule

// File: doc/swipt_bridge_pwm.md
Name: swipt_bridge_pwm

Overview:
- Parametrised full-bridge (H-bridge) gate-drive generator for the SWIPT transmitter.
- Produces four gate signals for the two bridge legs: left/right high side and left/right low side.
- Alternates positive drive, freewheel, negative drive and freewheel within each period, with programmable period, on-time and symmetric dead time.
- New settings pass through a valid/ready handshake into shadow registers that take effect only at a period boundary. It sits between the power-optimisation/data controller and the bridge gate drivers.

Parameters:
- CNT_W, 16: width of period/on-time counters (clk cycles).
- DEAD_W, 4: width of dead-time field.
- DEAD_RST, 14: dead time loaded at reset (cycles).

Ports:
- clk  in  1  clock.
- nrst  in  1  reset nrst, synchronous, active-low; clock clk.
- enable  in  1  run request; level-sensitive.
- cfg_valid  in  1  new configuration offered.
- cfg_ready  out  1  block can accept a configuration.
- cfg_period  in  CNT_W  full period P in cycles.
- cfg_on  in  CNT_W  drive time per half-period.
- cfg_dead  in  DEAD_W  dead time D in cycles.
- cfg_err  out  1  one-cycle pulse: rejected configuration.
- hs_l, hs_r  out  1 each  high-side gates (left, right).
- ls_l, ls_r  out  1 each  low-side gates (left, right).
- period_start  out  1  one-cycle pulse at cnt==0.
- active  out  1  high while in RUN or STOP.

Behaviour:
- Reset values:
  - hs_l = hs_r = 0; ls_l = ls_r = 1 (bridge freewheels to GND).
  - cfg_ready = 1; cfg_err = 0; period_start = 0; active = 0.
  - State IDLE. Shadow and live registers: P = 0, ON = 0, D = DEAD_RST. The pending flag is cleared.
  - Reset mid-operation takes effect on the next clk edge regardless of state.
- Configuration:
  - A transfer occurs when cfg_valid && cfg_ready.
  - Valid means 4 <= cfg_period and cfg_on <= cfg_period>>1. Otherwise cfg_err pulses the next cycle and the shadow registers are unchanged.
  - A valid transfer loads the shadow registers and sets pending. cfg_ready = !pending.
  - In IDLE, shadow is copied to live on the next cycle.
  - In RUN, the copy happens on the cycle cnt wraps from P-1 to 0. pending clears on the copy.
- State machine:
  - IDLE→RUN when enable && live P >= 4. Next cycle cnt = 0 and period_start = 1.
  - RUN→STOP when enable is sampled low. STOP completes the current period, then goes to IDLE at the wrap. The block never truncates a period.
  - STOP→RUN if enable returns high before the wrap.
- Counter and demand:
  - cnt runs 0..P-1 and wraps. H = P>>1.
  - Positive half is cnt < H; negative half is cnt >= H (length P-H, so odd P gives a longer negative half).
  - drv_pos = cnt < ON. drv_neg = cnt >= H && (cnt-H) < ON.
  - Leg-L demand is high while drv_pos; leg-R demand is high while drv_neg; otherwise low (freewheel).
  - Demand is registered, so gates follow the counter with a latency of 1 cycle.
- Dead-time inserter (per leg, independent):
  - On any change of leg demand, both hs and ls of that leg go 0 for D cycles, then the demanded switch turns on.
  - With D = 0 the switch is direct, with no gap.
  - If demand reverts during the dead window, the window restarts with the new demand.
  - Invariant: hs_x && ls_x is never 1.
  - If ON <= D, the high side never asserts; this is legal.
  - D is taken from live registers only.
- Simultaneous events:
  - Config accepted in the same cycle as a wrap: it is not applied at that wrap, but at the next one.
  - Reset has priority over everything.
  - In IDLE, outputs hold the reset values.

Optional Feature:
- Macro: SWIPT_DUTY_PERMILLE_EN.
- When defined, cfg_on is per-mille of the half-period. Values above 1000 are clamped to 1000. The effective ON = (H*cfg_on)/1000, computed on the copy to live using the new P, and the validity check ignores cfg_on.
- When undefined, cfg_on is an absolute cycle count as above.

Test Plan:
- Reset, then hold idle 10 cycles → hs_l = hs_r = 0, ls_l = ls_r = 1, active = 0, cfg_ready = 1.
- Load P=20, ON=6, D=2, enable=1 → period_start every 20 cycles; hs_l high 4 cycles per period starting at cnt 3; hs_r high 4 cycles starting at cnt 13; ls_l/ls_r low around each pulse as specified; never hs && ls on a leg.
- While running, load P=40, ON=10 at cnt 5 → cfg_ready=0 until the wrap; the new period takes effect exactly at the next cnt==0 and cfg_ready returns to 1.
- cfg_period=3, or cfg_on=11 with cfg_period=20 → cfg_err one-cycle pulse; waveform unchanged.
- Deassert enable at cnt 7 → the period completes to cnt 19, then IDLE, active=0; nrst low mid-pulse → reset values on the next edge.
- With SWIPT_DUTY_PERMILLE_EN: P=20, cfg_on=500 → ON=5; cfg_on=1500 → ON=10.
